// File: rtl/b16_sfr_pkg.sv
// Shared constants for the b16 SFR bus: port widths, arbiter state encoding
// and master indices.
package b16_sfr_pkg;

  localparam int SFR_AW = 8;
  localparam int SFR_DW = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACC  = 2'd1;
  localparam state_t ST_ACK  = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/sfr_arb_pick.sv
// Two-way grant select used when the arbiter is idle.
// Round-robin favours the master that did not win last; fixed mode favours m0.
module sfr_arb_pick
  import b16_sfr_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_vld,
  output logic       gnt
);

  always_comb begin
    gnt_vld = |req;
    if (&req) gnt = RR ? ~last_grant : M0;
    else      gnt = req[1] ? M1 : M0;
  end

endmodule

// File: rtl/sfr_bus_arb.sv
// Shares the single SFR port between the b16 core (m0) and the debug host (m1).
// Each access is a registered one-cycle bus slot followed by a one-cycle ack.
module sfr_bus_arb
  import b16_sfr_pkg::*;
#(
  parameter int AW = SFR_AW,
  parameter int DW = SFR_DW,
  parameter bit RR = 1'b1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_r,
  input  logic [1:0]    m0_w,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_r,
  input  logic [1:0]    m1_w,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          sfr_sel,
  output logic [AW-1:0] sfr_addr,
  output logic          sfr_r,
  output logic [1:0]    sfr_w,
  output logic [DW-1:0] sfr_dwrite,
  input  logic [DW-1:0] sfr_data
);

  logic [1:0]         req;
  logic [1:0][AW-1:0] addr_in;
  logic [1:0]         r_in;
  logic [1:0][1:0]    w_in;
  logic [1:0][DW-1:0] wdata_in;

  assign req      = {m1_req, m0_req};
  assign addr_in  = {m1_addr, m0_addr};
  assign r_in     = {m1_r, m0_r};
  assign w_in     = {m1_w, m0_w};
  assign wdata_in = {m1_wdata, m0_wdata};

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic               sel_q, sel_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               r_q, r_d;
  logic [1:0]         w_q, w_d;
  logic [DW-1:0]      dwrite_q, dwrite_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;

  logic pick_vld, pick_gnt;
  logic issue, issue_m;

  sfr_arb_pick #(.RR(RR)) u_pick (
    .req        (req),
    .last_grant (last_q),
    .gnt_vld    (pick_vld),
    .gnt        (pick_gnt)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= M0;
      last_q   <= M1;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      r_q      <= 1'b0;
      w_q      <= '0;
      dwrite_q <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      r_q      <= r_d;
      w_q      <= w_d;
      dwrite_q <= dwrite_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  // In ACK the finishing master's req is still high while it sees its ack,
  // so only the other master may be handed the bus directly.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    issue_m = M0;
    case (state_q)
      ST_IDLE: if (pick_vld) begin
        issue   = 1'b1;
        issue_m = pick_gnt;
        state_d = ST_ACC;
      end
      ST_ACC: state_d = ST_ACK;
      ST_ACK: if (req[~gnt_q]) begin
        issue   = 1'b1;
        issue_m = ~gnt_q;
        state_d = ST_ACC;
      end else begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d    = 1'b0;
    r_d      = 1'b0;
    w_d      = '0;
    addr_d   = addr_q;
    dwrite_d = dwrite_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    if (issue) begin
      sel_d    = 1'b1;
      addr_d   = addr_in[issue_m];
      r_d      = r_in[issue_m];
      w_d      = w_in[issue_m];
      dwrite_d = wdata_in[issue_m];
      gnt_d    = issue_m;
      last_d   = issue_m;
    end
    if (state_q == ST_ACC) begin
      ack_d[gnt_q]   = 1'b1;
      rdata_d[gnt_q] = sfr_data;
    end
  end

  assign sfr_sel    = sel_q;
  assign sfr_addr   = addr_q;
  assign sfr_r      = r_q;
  assign sfr_w      = w_q;
  assign sfr_dwrite = dwrite_q;
  assign m0_ack     = ack_q[0];
  assign m1_ack     = ack_q[1];
  assign m0_rdata   = rdata_q[0];
  assign m1_rdata   = rdata_q[1];

endmodule

// File: tb/tb_sfr_bus_arb.sv
// Directed bench for sfr_bus_arb: an LED7/timer SFR model on the round-robin
// instance plus a fixed-priority instance sharing the same master inputs.
module tb_sfr_bus_arb;

  logic        clk = 1'b0;
  logic        nreset;
  logic        m0_req, m0_r, m1_req, m1_r;
  logic [7:0]  m0_addr, m1_addr;
  logic [1:0]  m0_w, m1_w;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic        sfr_sel, sfr_r;
  logic [7:0]  sfr_addr;
  logic [1:0]  sfr_w;
  logic [15:0] sfr_dwrite, sfr_data;

  logic        f_m0_ack, f_m1_ack, f_sel, f_r;
  logic [15:0] f_m0_rdata, f_m1_rdata, f_dwrite;
  logic [7:0]  f_addr;
  logic [1:0]  f_w;
  logic [15:0] f_sfr_data = 16'h0;

  logic [15:0] led = 16'h0;
  logic [15:0] tmr = 16'h1000;
  logic [15:0] exp_t;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  sfr_bus_arb #(.AW(8), .DW(16), .RR(1'b1)) dut (
    .clk(clk), .nreset(nreset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_r(m0_r), .m0_w(m0_w), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_r(m1_r), .m1_w(m1_w), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .sfr_sel(sfr_sel), .sfr_addr(sfr_addr), .sfr_r(sfr_r), .sfr_w(sfr_w),
    .sfr_dwrite(sfr_dwrite), .sfr_data(sfr_data)
  );

  sfr_bus_arb #(.AW(8), .DW(16), .RR(1'b0)) dut_fix (
    .clk(clk), .nreset(nreset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_r(m0_r), .m0_w(m0_w), .m0_wdata(m0_wdata),
    .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_r(m1_r), .m1_w(m1_w), .m1_wdata(m1_wdata),
    .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata),
    .sfr_sel(f_sel), .sfr_addr(f_addr), .sfr_r(f_r), .sfr_w(f_w),
    .sfr_dwrite(f_dwrite), .sfr_data(f_sfr_data)
  );

  // SFR model: LED7 at 0x00 written on negedge per byte, free-running timer at 0x16.
  always @(negedge clk) begin
    if (sfr_sel && sfr_addr == 8'h00) begin
      if (sfr_w[0]) led[7:0]  <= sfr_dwrite[7:0];
      if (sfr_w[1]) led[15:8] <= sfr_dwrite[15:8];
    end
  end

  always @(posedge clk) tmr <= tmr + 16'd1;

  assign sfr_data = (sfr_sel && sfr_r) ?
                    ((sfr_addr == 8'h00) ? led : (sfr_addr == 8'h16) ? tmr : 16'h0) : 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic rq, input logic [7:0] a, input logic r,
                        input logic [1:0] w, input logic [15:0] d);
    m0_req = rq; m0_addr = a; m0_r = r; m0_w = w; m0_wdata = d;
  endtask

  task automatic set_m1(input logic rq, input logic [7:0] a, input logic r,
                        input logic [1:0] w, input logic [15:0] d);
    m1_req = rq; m1_addr = a; m1_r = r; m1_w = w; m1_wdata = d;
  endtask

  initial begin
    nreset = 1'b0;
    set_m0(1'b0, 8'h00, 1'b0, 2'b00, 16'h0);
    set_m1(1'b0, 8'h00, 1'b0, 2'b00, 16'h0);
    tick; tick;
    chk("rst_sel",    32'(sfr_sel),    32'h0);
    chk("rst_addr",   32'(sfr_addr),   32'h0);
    chk("rst_r",      32'(sfr_r),      32'h0);
    chk("rst_w",      32'(sfr_w),      32'h0);
    chk("rst_dwrite", 32'(sfr_dwrite), 32'h0);
    chk("rst_acks",   32'({m1_ack, m0_ack}), 32'h0);
    chk("rst_rdata",  32'({m1_rdata, m0_rdata}), 32'h0);
    nreset = 1'b1;
    tick;
    chk("idle_sel", 32'(sfr_sel), 32'h0);

    // m0 full-word write to LED7
    set_m0(1'b1, 8'h00, 1'b0, 2'b11, 16'h1234);
    tick;
    chk("t1_sel",    32'(sfr_sel),    32'h1);
    chk("t1_addr",   32'(sfr_addr),   32'h00);
    chk("t1_w",      32'(sfr_w),      32'h3);
    chk("t1_dwrite", 32'(sfr_dwrite), 32'h1234);
    chk("t1_noack",  32'(m0_ack),     32'h0);
    tick;
    chk("t1_ack",    32'(m0_ack),     32'h1);
    chk("t1_m1ack",  32'(m1_ack),     32'h0);
    chk("t1_seldrop",32'(sfr_sel),    32'h0);
    chk("t1_wdrop",  32'(sfr_w),      32'h0);
    chk("t1_dhold",  32'(sfr_dwrite), 32'h1234);
    chk("t1_led",    32'(led),        32'h1234);
    m0_req = 1'b0;
    tick;
    chk("t1_pulse",  32'(m0_ack),     32'h0);

    // m1 timer read
    set_m1(1'b1, 8'h16, 1'b1, 2'b00, 16'h0);
    tick;
    chk("t2_sel",  32'(sfr_sel),  32'h1);
    chk("t2_r",    32'(sfr_r),    32'h1);
    chk("t2_addr", 32'(sfr_addr), 32'h16);
    tick;
    exp_t = tmr - 16'd1;
    chk("t2_ack",    32'(m1_ack),   32'h1);
    chk("t2_rdata",  32'(m1_rdata), 32'(exp_t));
    chk("t2_m0keep", 32'(m0_rdata), 32'h0);
    chk("t2_ahold",  32'(sfr_addr), 32'h16);
    chk("t2_rdrop",  32'(sfr_r),    32'h0);
    m1_req = 1'b0;
    tick;
    chk("t2_pulse", 32'(m1_ack), 32'h0);

    // simultaneous requests, last grant was m1: m0 first, m1 via handoff
    set_m0(1'b1, 8'h00, 1'b1, 2'b00, 16'h0);
    set_m1(1'b1, 8'h00, 1'b0, 2'b10, 16'hCD00);
    tick;
    chk("t3_sel0", 32'(sfr_sel), 32'h1);
    chk("t3_r0",   32'(sfr_r),   32'h1);
    chk("t3_w0",   32'(sfr_w),   32'h0);
    tick;
    chk("t3_ack0",   32'({m1_ack, m0_ack}), 32'h1);
    chk("t3_rdata0", 32'(m0_rdata), 32'h1234);
    chk("t3_seloff", 32'(sfr_sel),  32'h0);
    m0_req = 1'b0;
    tick;
    chk("t3_sel1",   32'(sfr_sel),    32'h1);
    chk("t3_w1",     32'(sfr_w),      32'h2);
    chk("t3_d1",     32'(sfr_dwrite), 32'hCD00);
    chk("t3_noack",  32'({m1_ack, m0_ack}), 32'h0);
    tick;
    chk("t3_ack1",   32'({m1_ack, m0_ack}), 32'h2);
    chk("t3_rdata1", 32'(m1_rdata), 32'h0);
    chk("t3_led",    32'(led),      32'hCD34);
    m1_req = 1'b0;
    tick;
    chk("t3_idle",   32'(sfr_sel), 32'h0);

    // low-byte-only write
    set_m0(1'b1, 8'h00, 1'b0, 2'b01, 16'hAB55);
    tick; tick;
    chk("t4_ack", 32'(m0_ack), 32'h1);
    chk("t4_led", 32'(led),    32'hCD55);
    m0_req = 1'b0;
    tick;

    // continuous no-op requests: RR instance (last=m0) vs fixed-priority instance
    set_m0(1'b1, 8'h20, 1'b0, 2'b00, 16'h0);
    set_m1(1'b1, 8'h30, 1'b0, 2'b00, 16'h0);
    tick;
    chk("t5_rr_a1",  32'(sfr_addr), 32'h30);
    chk("t5_fx_a1",  32'(f_addr),   32'h20);
    chk("t5_fx_sel", 32'(f_sel),    32'h1);
    tick;
    chk("t5_rr_ack1", 32'({m1_ack, m0_ack}),     32'h2);
    chk("t5_fx_ack1", 32'({f_m1_ack, f_m0_ack}), 32'h1);
    tick;
    chk("t5_rr_a2",  32'(sfr_addr), 32'h20);
    chk("t5_fx_a2",  32'(f_addr),   32'h30);
    chk("t5_rr_sel", 32'(sfr_sel),  32'h1);
    tick;
    chk("t5_rr_ack2", 32'({m1_ack, m0_ack}),     32'h1);
    chk("t5_fx_ack2", 32'({f_m1_ack, f_m0_ack}), 32'h2);
    m0_req = 1'b0; m1_req = 1'b0;
    tick;
    chk("t5_idle",  32'({f_sel, sfr_sel}), 32'h0);
    chk("t5_noeff", 32'(led), 32'hCD55);
    m0_req = 1'b1; m1_req = 1'b1;
    tick;
    chk("t5_rr_a3", 32'(sfr_addr), 32'h30);
    chk("t5_fx_a3", 32'(f_addr),   32'h20);
    tick;
    chk("t5_rr_ack3", 32'({m1_ack, m0_ack}),     32'h2);
    chk("t5_fx_ack3", 32'({f_m1_ack, f_m0_ack}), 32'h1);
    m0_req = 1'b0; m1_req = 1'b0;
    tick; tick;

    // reset in the middle of a write slot
    set_m0(1'b1, 8'h00, 1'b0, 2'b11, 16'h7777);
    tick;
    chk("t6_sel", 32'(sfr_sel), 32'h1);
    @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    chk("t6_rsel",   32'(sfr_sel),    32'h0);
    chk("t6_raddr",  32'(sfr_addr),   32'h0);
    chk("t6_rdw",    32'(sfr_dwrite), 32'h0);
    chk("t6_rw",     32'(sfr_w),      32'h0);
    chk("t6_rack",   32'({m1_ack, m0_ack}), 32'h0);
    chk("t6_landed", 32'(led),        32'h7777);
    tick;
    chk("t6_held",   32'({sfr_sel, m1_ack, m0_ack}), 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    tick;
    chk("t6_resel", 32'(sfr_sel),    32'h1);
    chk("t6_redw",  32'(sfr_dwrite), 32'h7777);
    chk("t6_noack", 32'(m0_ack),     32'h0);
    tick;
    chk("t6_ack",   32'(m0_ack), 32'h1);
    m0_req = 1'b0;
    tick;
    chk("t6_once",  32'({sfr_sel, m0_ack}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
